apb_node_tmo: RTL and testbench

Parametrised APB 3 demultiplexer that succeeds the fixed ten-peripheral bus wrapper. It routes one upstream APB slave port to `NB_MASTER` downstream peripheral ports using runtime start/end address rules. The node fully registers each transfer, so downstream timing is decoupled from the core-side bridge. It answers unmapped addresses and stalled peripherals with `PSLVERR` instead of hanging the bus.

---
 rtl/apb_node_pkg.sv | 22 ++
 rtl/apb_addr_decode.sv | 29 ++
 rtl/apb_node_tmo.sv | 171 +++++++++++++++++
 tb/tb_apb_node_tmo.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_node_pkg.sv
// Shared definitions for the APB demultiplexer node: FSM states, error-cause
// codes reported on err_code_o, and the timeout counter width helper.
package apb_node_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DSETUP  = 2'd1,
    DACCESS = 2'd2,
    RESP    = 2'd3
  } apb_node_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DECODE  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_SLAVE   = 2'd3;

  // Bits needed to count from 0 up to and including tmo_cycles.
  function automatic int tmo_cnt_width(input int tmo_cycles);
    return $clog2(tmo_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational priority range decoder. Each port owns an inclusive
// [start, end] window; when windows overlap the lowest port index wins.
module apb_addr_decode
  import apb_node_pkg::*;
#(
  parameter int NB_MASTER  = 10,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 4
) (
  input  logic [ADDR_WIDTH-1:0]                 addr,
  input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0]  start_addr,
  input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0]  end_addr,
  output logic                                  hit,
  output logic [IDX_WIDTH-1:0]                  idx
);

  // Scan from the top index down so the last match written is the lowest one.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NB_MASTER - 1; i >= 0; i--) begin
      if ((addr >= start_addr[i]) && (addr <= end_addr[i])) begin
        hit = 1'b1;
        idx = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/apb_node_tmo.sv
// APB3 1-to-NB_MASTER demultiplexer with fully registered downstream transfer.
// Unmapped addresses and (optionally) stalled peripherals are answered with
// PSLVERR so the upstream bus never hangs.
// Optional feature: define APB_NODE_TIMEOUT_EN to build the downstream
// timeout counter and abort path; without it DACCESS waits indefinitely.
module apb_node_tmo
  import apb_node_pkg::*;
#(
  parameter int NB_MASTER      = 10,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0]                paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]                pwdata_i,
  input  logic                                     pwrite_i,
  input  logic                                     psel_i,
  input  logic                                     penable_i,
  output logic [APB_DATA_WIDTH-1:0]                prdata_o,
  output logic                                     pready_o,
  output logic                                     pslverr_o,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] end_addr_i,
  output logic [APB_ADDR_WIDTH-1:0]                m_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                m_pwdata_o,
  output logic                                     m_pwrite_o,
  output logic [NB_MASTER-1:0]                     m_psel_o,
  output logic [NB_MASTER-1:0]                     m_penable_o,
  input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] m_prdata_i,
  input  logic [NB_MASTER-1:0]                     m_pready_i,
  input  logic [NB_MASTER-1:0]                     m_pslverr_i,
  output logic                                     err_o,
  output logic [1:0]                               err_code_o
);

  localparam int IDX_W = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;

  apb_node_state_e           state_q, state_d;
  logic [IDX_W-1:0]          idx_q;
  logic [IDX_W-1:0]          dec_idx;
  logic                      dec_hit;
  logic [APB_DATA_WIDTH-1:0] prdata_q;
  logic                      pslverr_q;
  logic                      start_req;
  logic                      dec_miss;
  logic                      slv_done;
  logic [NB_MASTER-1:0]      port_onehot;

`ifdef APB_NODE_TIMEOUT_EN
  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_abort;
`endif

  apb_addr_decode #(
    .NB_MASTER (NB_MASTER),
    .ADDR_WIDTH(APB_ADDR_WIDTH),
    .IDX_WIDTH (IDX_W)
  ) u_decode (
    .addr      (paddr_i),
    .start_addr(start_addr_i),
    .end_addr  (end_addr_i),
    .hit       (dec_hit),
    .idx       (dec_idx)
  );

  // State register; async reset lands in IDLE so downstream selects drop at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and the one-cycle capture strobes used by the datapath.
  always_comb begin
    state_d   = state_q;
    start_req = 1'b0;
    dec_miss  = 1'b0;
    slv_done  = 1'b0;
`ifdef APB_NODE_TIMEOUT_EN
    tmo_abort = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          start_req = 1'b1;
          if (dec_hit) begin
            state_d = DSETUP;
          end else begin
            dec_miss = 1'b1;
            state_d  = RESP;
          end
        end
      end
      DSETUP: state_d = DACCESS;
      DACCESS: begin
        if (m_pready_i[idx_q]) begin
          slv_done = 1'b1;
          state_d  = RESP;
        end
`ifdef APB_NODE_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_LAST) begin
          tmo_abort = 1'b1;
          state_d   = RESP;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture in IDLE and response capture on leaving DACCESS or on a miss.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_paddr_o  <= '0;
      m_pwdata_o <= '0;
      m_pwrite_o <= 1'b0;
      idx_q      <= '0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      err_code_o <= ERR_NONE;
    end else begin
      if (start_req) begin
        m_paddr_o  <= paddr_i;
        m_pwdata_o <= pwdata_i;
        m_pwrite_o <= pwrite_i;
        idx_q      <= dec_idx;
      end
      if (dec_miss) begin
        prdata_q   <= '0;
        pslverr_q  <= 1'b1;
        err_code_o <= ERR_DECODE;
      end
      if (slv_done) begin
        prdata_q  <= m_pwrite_o ? '0 : m_prdata_i[idx_q];
        pslverr_q <= m_pslverr_i[idx_q];
        if (m_pslverr_i[idx_q]) err_code_o <= ERR_SLAVE;
      end
`ifdef APB_NODE_TIMEOUT_EN
      if (tmo_abort) begin
        prdata_q   <= '0;
        pslverr_q  <= 1'b1;
        err_code_o <= ERR_TIMEOUT;
      end
`endif
    end
  end

`ifdef APB_NODE_TIMEOUT_EN
  // Access-phase cycle counter: cleared while in DSETUP, counts each stalled DACCESS cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 tmo_cnt_q <= '0;
    else if (state_q == DSETUP)  tmo_cnt_q <= '0;
    else if (state_q == DACCESS) tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`endif

  assign port_onehot = NB_MASTER'(1) << idx_q;

  assign m_psel_o    = ((state_q == DSETUP) || (state_q == DACCESS)) ? port_onehot : '0;
  assign m_penable_o = (state_q == DACCESS) ? port_onehot : '0;

  assign pready_o  = (state_q == RESP);
  assign prdata_o  = pready_o ? prdata_q : '0;
  assign pslverr_o = pready_o & pslverr_q;
  assign err_o     = pready_o & pslverr_q;

endmodule

// File: tb/tb_apb_node_tmo.sv
// Self-checking bench for apb_node_tmo: directed cases plus randomized
// transfers, each compared against a transaction-level reference model.
module tb_apb_node_tmo;

  localparam int NB    = 10;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TMO   = 8;
  localparam int LIMIT = 100;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [AW-1:0]          paddr;
  logic [DW-1:0]          pwdata;
  logic                   pwrite;
  logic                   psel;
  logic                   penable;
  logic [DW-1:0]          prdata;
  logic                   pready;
  logic                   pslverr;
  logic [NB-1:0][AW-1:0]  start_addr;
  logic [NB-1:0][AW-1:0]  end_addr;
  logic [AW-1:0]          m_paddr;
  logic [DW-1:0]          m_pwdata;
  logic                   m_pwrite;
  logic [NB-1:0]          m_psel;
  logic [NB-1:0]          m_penable;
  logic [NB-1:0][DW-1:0]  m_prdata;
  logic [NB-1:0]          m_pready;
  logic [NB-1:0]          m_pslverr;
  logic                   err;
  logic [1:0]             err_code;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [1:0] exp_code;

  always #5 clk = ~clk;

  apb_node_tmo #(
    .NB_MASTER     (NB),
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .paddr_i     (paddr),
    .pwdata_i    (pwdata),
    .pwrite_i    (pwrite),
    .psel_i      (psel),
    .penable_i   (penable),
    .prdata_o    (prdata),
    .pready_o    (pready),
    .pslverr_o   (pslverr),
    .start_addr_i(start_addr),
    .end_addr_i  (end_addr),
    .m_paddr_o   (m_paddr),
    .m_pwdata_o  (m_pwdata),
    .m_pwrite_o  (m_pwrite),
    .m_psel_o    (m_psel),
    .m_penable_o (m_penable),
    .m_prdata_i  (m_prdata),
    .m_pready_i  (m_pready),
    .m_pslverr_i (m_pslverr),
    .err_o       (err),
    .err_code_o  (err_code)
  );

  task automatic checkOutput(input string tag, input string what,
                             input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s.%s observed=0x%0h expected=0x%0h", tag, what, observed, expected);
    end
  endtask

  // Address map rule: the lowest-numbered port whose inclusive window holds the address.
  function automatic void model_decode(input logic [31:0] a, output bit hit, output int port);
    hit  = 1'b0;
    port = 0;
    for (int i = 0; i < NB; i++) begin
      if (!hit && a >= start_addr[i] && a <= end_addr[i]) begin
        hit  = 1'b1;
        port = i;
      end
    end
  endfunction

  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic wr,
                               input logic [31:0] wdata, input int wait_n, input bit never_rdy,
                               input bit slverr, input bit drop_psel);
    bit            hit, got, timed_out;
    int            port, n, dacc, psel_cyc, err_cnt;
    int            exp_cycles, exp_psel_cyc;
    logic [NB-1:0] psel_or, exp_psel;
    logic [31:0]   rdata, got_rdata, exp_rdata;
    logic          got_err, exp_err;

    rdata = $urandom;
    model_decode(addr, hit, port);
    for (int i = 0; i < NB; i++) m_prdata[i] = (hit && i == port) ? rdata : $urandom;
    m_pslverr = (hit && slverr) ? (NB'(1) << port) : '0;
    m_pready  = '0;

    timed_out = 1'b0;
`ifdef APB_NODE_TIMEOUT_EN
    if (hit && (never_rdy || wait_n >= TMO)) timed_out = 1'b1;
`endif
    if (!hit) begin
      exp_cycles = 1;  exp_psel_cyc = 0;  exp_psel = '0;
      exp_rdata = 32'h0;  exp_err = 1'b1;  exp_code = 2'd1;
    end else if (timed_out) begin
      exp_cycles = TMO + 2;  exp_psel_cyc = TMO + 1;  exp_psel = NB'(1) << port;
      exp_rdata = 32'h0;  exp_err = 1'b1;  exp_code = 2'd2;
    end else begin
      exp_cycles = wait_n + 3;  exp_psel_cyc = wait_n + 2;  exp_psel = NB'(1) << port;
      exp_rdata = wr ? 32'h0 : rdata;  exp_err = slverr;
      if (slverr) exp_code = 2'd3;
    end

    @(negedge clk);
    paddr = addr;  pwdata = wdata;  pwrite = wr;  psel = 1'b1;  penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    n = 1;  dacc = 0;  psel_cyc = 0;  err_cnt = 0;  psel_or = '0;  got = 1'b0;
    got_rdata = '0;  got_err = 1'b0;
    while (n <= LIMIT) begin
      if (m_psel != '0) begin
        psel_or |= m_psel;
        psel_cyc++;
      end
      if (err) err_cnt++;
      if (m_penable != '0) begin
        m_pready = (!never_rdy && dacc == wait_n) ? m_penable : '0;
        dacc++;
      end else begin
        m_pready = '0;
      end
      if (pready) begin
        got = 1'b1;  got_rdata = prdata;  got_err = pslverr;
        break;
      end
      if (drop_psel && n == 1) begin
        psel = 1'b0;  penable = 1'b0;
      end
      @(negedge clk);
      n++;
    end

    checkOutput(tag, "ready_seen", {31'd0, got}, 32'd1);
    checkOutput(tag, "ready_cycle", n, exp_cycles);
    checkOutput(tag, "prdata", got_rdata, exp_rdata);
    checkOutput(tag, "pslverr", {31'd0, got_err}, {31'd0, exp_err});
    checkOutput(tag, "err_code", {30'd0, err_code}, {30'd0, exp_code});

    @(negedge clk);
    psel = 1'b0;  penable = 1'b0;  m_pready = '0;
    if (err) err_cnt++;
    checkOutput(tag, "pready_after", {31'd0, pready}, 32'd0);
    checkOutput(tag, "prdata_after", prdata, 32'd0);
    @(negedge clk);
    if (err) err_cnt++;

    checkOutput(tag, "err_pulses", err_cnt, exp_err ? 1 : 0);
    checkOutput(tag, "psel_port", {22'd0, psel_or}, {22'd0, exp_psel});
    checkOutput(tag, "psel_cycles", psel_cyc, exp_psel_cyc);
    checkOutput(tag, "m_paddr_hold", m_paddr, addr);
    checkOutput(tag, "m_pwrite_hold", {31'd0, m_pwrite}, {31'd0, wr});
    checkOutput(tag, "m_pwdata_hold", m_pwdata, wdata);
  endtask

  initial begin
    #1_000_000;
    $fatal(1, "[TB] watchdog expired before the bench completed");
  end

  initial begin
    logic [31:0] span, addr;
    int          p;

    start_addr[0] = 32'h1000_0000;  end_addr[0] = 32'h1000_FFFF;
    start_addr[1] = 32'h1A10_0000;  end_addr[1] = 32'h1A10_0FFF;
    start_addr[2] = 32'h1A10_2000;  end_addr[2] = 32'h1A10_2FFF;
    start_addr[3] = 32'h2003_0000;  end_addr[3] = 32'h2003_FFFF;
    start_addr[4] = 32'h2004_0000;  end_addr[4] = 32'h2004_FFFF;
    start_addr[5] = 32'h2003_8000;  end_addr[5] = 32'h2005_FFFF;
    start_addr[6] = 32'h3000_0000;  end_addr[6] = 32'h3000_00FF;
    start_addr[7] = 32'h4000_0000;  end_addr[7] = 32'h4FFF_FFFF;
    start_addr[8] = 32'h8000_0000;  end_addr[8] = 32'h8000_0000;
    start_addr[9] = 32'hF000_0000;  end_addr[9] = 32'hFFFF_FFFF;

    rst_n = 1'b0;  paddr = '0;  pwdata = '0;  pwrite = 1'b0;  psel = 1'b0;  penable = 1'b0;
    m_prdata = '0;  m_pready = '0;  m_pslverr = '0;  exp_code = 2'd0;

    #1;
    checkOutput("reset", "m_psel", {22'd0, m_psel}, 32'd0);
    checkOutput("reset", "pready", {31'd0, pready}, 32'd0);
    checkOutput("reset", "err_code", {30'd0, err_code}, 32'd0);
    checkOutput("reset", "m_paddr", m_paddr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("wr_zero_wait", 32'h1A10_0004, 1'b1, 32'h1234_5678, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus("rd_wait4",     32'h1A10_2000, 1'b0, 32'h0,        4, 1'b0, 1'b0, 1'b0);
    applyStimulus("rd_unmapped",  32'h0000_0000, 1'b0, 32'h0,        0, 1'b0, 1'b0, 1'b0);
`ifdef APB_NODE_TIMEOUT_EN
    applyStimulus("timeout",      32'h3000_0010, 1'b0, 32'h0,        0, 1'b1, 1'b0, 1'b0);
`else
    applyStimulus("long_wait",    32'h3000_0010, 1'b0, 32'h0,       20, 1'b0, 1'b0, 1'b0);
`endif
    applyStimulus("ready_at_limit", 32'h3000_00FF, 1'b0, 32'h0, TMO - 1, 1'b0, 1'b0, 1'b0);
    applyStimulus("overlap_3_5",  32'h2003_9000, 1'b0, 32'h0,        1, 1'b0, 1'b1, 1'b0);
    applyStimulus("rule_end",     32'h1A10_0FFF, 1'b1, 32'hA5A5_0001, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus("rule_end_p1",  32'h1A10_1000, 1'b1, 32'hA5A5_0002, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus("single_addr",  32'h8000_0000, 1'b0, 32'h0,        2, 1'b0, 1'b0, 1'b0);
    applyStimulus("top_addr",     32'hFFFF_FFFF, 1'b1, 32'hDEAD_BEEF, 1, 1'b0, 1'b1, 1'b0);
    applyStimulus("psel_dropped", 32'h2005_0100, 1'b0, 32'h0,        3, 1'b0, 1'b0, 1'b1);

    // Reset asserted while the downstream port is in its access phase.
    m_pready = '0;  m_pslverr = '0;
    @(negedge clk);
    paddr = 32'h2004_1234;  pwrite = 1'b0;  psel = 1'b1;  penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid", "penable_before", {22'd0, m_penable}, 32'h10);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid", "m_psel", {22'd0, m_psel}, 32'd0);
    checkOutput("rst_mid", "m_penable", {22'd0, m_penable}, 32'd0);
    checkOutput("rst_mid", "pready", {31'd0, pready}, 32'd0);
    checkOutput("rst_mid", "pslverr", {31'd0, pslverr}, 32'd0);
    checkOutput("rst_mid", "err", {31'd0, err}, 32'd0);
    checkOutput("rst_mid", "err_code", {30'd0, err_code}, 32'd0);
    checkOutput("rst_mid", "m_paddr", m_paddr, 32'd0);
    psel = 1'b0;  penable = 1'b0;  exp_code = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("after_reset", 32'h2004_1234, 1'b0, 32'h0, 1, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        addr = $urandom_range(0, 32'h0FFF_FFFF);
      end else begin
        p    = $urandom_range(0, NB - 1);
        span = end_addr[p] - start_addr[p] + 32'd1;
        addr = start_addr[p] + ($urandom % span);
      end
      applyStimulus($sformatf("rand%0d", k), addr, 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(0, 5), 1'b0, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
